acc_cpu_core: RTL and testbench
===============================

# acc_cpu_core

Parametrised accumulator CPU core. Generalises the existing fixed-width accumulator/register1 CPU into a core with a configurable data width, PC width and register-file depth. Adds a valid/ready-style instruction-fetch handshake, carry/zero flags, conditional jumps, HALT and illegal-opcode reporting. It sits between the instruction memory and the top-level testbench/monitor, and exposes debug taps for the PC, instruction, accumulator and a selectable register.

## Interface
- REGISTER_WIDTH, 8, accumulator/register/immediate width (≥ PC_WIDTH)
- PC_WIDTH, 8, program counter width; PC wraps modulo 2^PC_WIDTH
- NUM_REGS, 4, register-file depth (power of 2, ≥2); REG_IDX = log2(NUM_REGS)
- INSTRUCTION_WIDTH, 4+REGISTER_WIDTH, opcode [IW-1:IW-4], immediate [REGISTER_WIDTH-1:0]; register index = imm[REG_IDX-1:0]

Ports:
- clock  in  1  single clock, rising edge
- isReset  in  1  synchronous, active-high reset
- instrReq  out  1  fetch request; held high until accepted
- instrAddr  out  PC_WIDTH  fetch address (= pc while instrReq)
- instrValid  in  1  instruction data valid; sampled only while instrReq=1
- instrData  in  INSTRUCTION_WIDTH  fetched instruction
- debugRegSel  in  REG_IDX  register-file read select for debug
- pc  out  PC_WIDTH  current PC
- instruction  out  INSTRUCTION_WIDTH  last accepted instruction
- accumulator  out  REGISTER_WIDTH  accumulator
- debugRegData  out  REGISTER_WIDTH  regs[debugRegSel], combinational
- aluResult  out  REGISTER_WIDTH  last ALU output, registered
- carry, zero  out  1 each  flags
- halted  out  1  high in HALTED state
- illegal  out  1  one-cycle pulse on an illegal opcode

## Operation
- States: FETCH, EXECUTE, HALTED.
- FETCH: instrReq=1, instrAddr=pc. When instrValid=1, latch instrData into instruction and go to EXECUTE. Otherwise stay.
- EXECUTE, one cycle, then go to FETCH (or HALTED). Default pc <= pc+1. Opcodes:
  - 0 NOP
  - 1 LDI: acc=imm
  - 2 ADD: acc=acc+R
  - 3 SUB: acc=acc−R
  - 4 AND: acc=acc&R
  - 5 OR: acc=acc|R
  - 6 XOR: acc=acc^R
  - 7 STR: R=acc
  - 8 LDR: acc=R
  - 9 ADDI: acc=acc+imm
  - A JMP: pc=imm[PC_WIDTH-1:0]
  - B JZ: jump if zero=1, else pc+1
  - C JC: jump if carry=1, else pc+1
  - D HALT: go to HALTED; pc not incremented
  - E/F: illegal; behave as NOP and pulse illegal
- R = regs[imm[REG_IDX-1:0]]; upper immediate bits are ignored for register ops.
- Arithmetic is REGISTER_WIDTH+1 wide:
  - ADD/ADDI: carry = bit REGISTER_WIDTH of the sum.
  - SUB: carry = 1 on borrow (acc < R).
  - Result truncated to REGISTER_WIDTH.
- aluResult and zero (result==0) update on opcodes 1–6, 8, 9. carry updates on 2, 3, 9 only; AND/OR/XOR/LDI/LDR leave carry unchanged. All other opcodes leave flags and aluResult unchanged.
- STR to the register selected by debugRegSel is visible on debugRegData the cycle after EXECUTE.
- HALTED: terminal. instrReq=0; all state frozen. Only isReset exits.

## Timing
- Reset state, applied on the first rising edge with isReset=1:
  - state=FETCH, pc=0, instruction=0, accumulator=0, aluResult=0, carry=0, zero=0, halted=0, illegal=0.
  - All regs=0.
  - instrReq=0 during the reset cycle; 1 on the first cycle after reset deasserts.
- Reset dominates every state, including mid-fetch with instrValid=1 (data discarded) and HALTED.
- Fetch latency is arbitrary: 0 or more cycles of instrValid=0. instrValid with instrReq=0 is ignored.
- Minimum CPI = 2: accept in FETCH at cycle n, EXECUTE at n+1, next instrReq at n+2. All outputs update on the EXECUTE clock edge.
- PC wrap: pc=2^PC_WIDTH−1 plus a non-jump instruction gives pc=0. Jump target wraps by truncation.
- illegal is high exactly for the EXECUTE cycle of an E/F opcode.

## Test plan
(REGISTER_WIDTH=8, PC_WIDTH=8, NUM_REGS=4)
- Reset/zero-wait fetch:
  - Stimulus: reset 2 cycles; memory returns same-cycle data. Program LDI 0x05, STR r1, ADDI 0x03, HALT.
  - Required: acc=0x08, regs[1]=0x05, halted=1, pc=3, instrReq=0 afterwards.
- Carry/borrow:
  - Stimulus: LDI 0xFF; STR r2; LDI 0x01; ADD r2; then SUB r2.
  - Required: ADD gives acc=0x00, carry=1, zero=1. SUB gives acc=0x01, carry=1 (borrow), zero=0.
- Conditional jumps:
  - Stimulus: LDI 0; JZ 0x10.
  - Required: pc=0x10.
  - Stimulus: LDI 1; JZ 0x10.
  - Required: falls through to pc+1.
  - Stimulus: JC with carry=0.
  - Required: no jump.
- Wait states and reset mid-fetch:
  - Stimulus: instrValid delayed 3 cycles. Required: instrReq stays high, pc stable, instruction accepted on the 4th cycle.
  - Stimulus: assert isReset while instrReq=1 and instrValid=1. Required: instruction discarded; all outputs at reset values.
- PC wrap and illegal:
  - Stimulus: JMP 0xFF with 0xFF holding NOP.
  - Required: next fetch at instrAddr=0x00.
  - Stimulus: opcode 0xE.
  - Required: illegal pulses 1 cycle; acc and flags unchanged.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU with a valid/ready instruction
// fetch, a small register file, carry/zero flags, conditional jumps, HALT
// and illegal-opcode reporting. Each instruction takes a FETCH cycle (plus
// any wait states) followed by a single EXECUTE cycle.
module acc_cpu_core #(
  parameter int REGISTER_WIDTH    = 8,
  parameter int PC_WIDTH          = 8,
  parameter int NUM_REGS          = 4,
  parameter int INSTRUCTION_WIDTH = 4 + REGISTER_WIDTH,
  localparam int REG_IDX          = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         isReset,
  output logic                         instrReq,
  output logic [PC_WIDTH-1:0]          instrAddr,
  input  logic                         instrValid,
  input  logic [INSTRUCTION_WIDTH-1:0] instrData,
  input  logic [REG_IDX-1:0]           debugRegSel,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [REGISTER_WIDTH-1:0]    accumulator,
  output logic [REGISTER_WIDTH-1:0]    debugRegData,
  output logic [REGISTER_WIDTH-1:0]    aluResult,
  output logic                         carry,
  output logic                         zero,
  output logic                         halted,
  output logic                         illegal
);

  typedef enum logic [1:0] {FETCH, EXECUTE, HALTED} state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_LDR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  state_t                    state, state_nxt;
  logic [REGISTER_WIDTH-1:0] regs [NUM_REGS];

  logic [3:0]                opc;
  logic [REGISTER_WIDTH-1:0] imm;
  logic [REG_IDX-1:0]        ridx;
  logic [REGISTER_WIDTH-1:0] rval;
  logic [PC_WIDTH-1:0]       jmp_tgt;
  logic [PC_WIDTH-1:0]       pc_inc;

  // The extra top bit of sum carries the ADD/ADDI carry-out and the SUB borrow
  logic [REGISTER_WIDTH:0]   sum;
  logic [REGISTER_WIDTH-1:0] res;
  logic                      upd_alu;
  logic                      upd_carry;
  logic [PC_WIDTH-1:0]       pc_nxt;

  assign opc          = instruction[INSTRUCTION_WIDTH-1 -: 4];
  assign imm          = instruction[REGISTER_WIDTH-1:0];
  assign ridx         = imm[REG_IDX-1:0];
  assign rval         = regs[ridx];
  assign jmp_tgt      = imm[PC_WIDTH-1:0];
  assign pc_inc       = pc + PC_WIDTH'(1);
  assign res          = sum[REGISTER_WIDTH-1:0];
  assign instrAddr    = pc;
  assign debugRegData = regs[debugRegSel];

  // ALU result, flag-update enables and next PC for the current instruction
  always_comb begin
    sum       = '0;
    upd_alu   = 1'b0;
    upd_carry = 1'b0;
    pc_nxt    = pc_inc;
    case (opc)
      OP_LDI:  begin sum = {1'b0, imm};                      upd_alu = 1'b1; end
      OP_ADD:  begin sum = {1'b0, accumulator} + {1'b0, rval}; upd_alu = 1'b1; upd_carry = 1'b1; end
      OP_SUB:  begin sum = {1'b0, accumulator} - {1'b0, rval}; upd_alu = 1'b1; upd_carry = 1'b1; end
      OP_AND:  begin sum = {1'b0, accumulator & rval};       upd_alu = 1'b1; end
      OP_OR:   begin sum = {1'b0, accumulator | rval};       upd_alu = 1'b1; end
      OP_XOR:  begin sum = {1'b0, accumulator ^ rval};       upd_alu = 1'b1; end
      OP_LDR:  begin sum = {1'b0, rval};                     upd_alu = 1'b1; end
      OP_ADDI: begin sum = {1'b0, accumulator} + {1'b0, imm}; upd_alu = 1'b1; upd_carry = 1'b1; end
      OP_JMP:  pc_nxt = jmp_tgt;
      OP_JZ:   pc_nxt = zero  ? jmp_tgt : pc_inc;
      OP_JC:   pc_nxt = carry ? jmp_tgt : pc_inc;
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  // Control FSM: next state, fetch request and status outputs
  always_comb begin
    state_nxt = state;
    instrReq  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        instrReq = !isReset;
        if (instrValid) state_nxt = EXECUTE;
      end
      EXECUTE: begin
        illegal   = (opc == 4'hE) || (opc == 4'hF);
        state_nxt = (opc == OP_HALT) ? HALTED : FETCH;
      end
      HALTED: halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  // State register plus architectural state, written on fetch accept / execute
  always_ff @(posedge clock) begin
    if (isReset) begin
      state       <= FETCH;
      pc          <= '0;
      instruction <= '0;
      accumulator <= '0;
      aluResult   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && instrValid) instruction <= instrData;
      if (state == EXECUTE) begin
        pc <= pc_nxt;
        if (upd_alu) begin
          accumulator <= res;
          aluResult   <= res;
          zero        <= (res == '0);
        end
        if (upd_carry) carry <= sum[REGISTER_WIDTH];
        if (opc == OP_STR) regs[ridx] <= accumulator;
      end
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: a table of single instructions with the
// expected architectural state after each, then hand-written sequences for
// HALTED hold, reset from HALTED, reset mid-fetch and fetch wait states.
module tb_acc_cpu_core;
  localparam int RW = 8;
  localparam int PW = 8;
  localparam int NR = 4;
  localparam int IW = 12;
  localparam int RI = 2;

  logic          clock = 1'b0;
  logic          isReset;
  logic          instrReq;
  logic [PW-1:0] instrAddr;
  logic          instrValid;
  logic [IW-1:0] instrData;
  logic [RI-1:0] debugRegSel;
  logic [PW-1:0] pc;
  logic [IW-1:0] instruction;
  logic [RW-1:0] accumulator;
  logic [RW-1:0] debugRegData;
  logic [RW-1:0] aluResult;
  logic          carry, zero, halted, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  acc_cpu_core #(.REGISTER_WIDTH(RW), .PC_WIDTH(PW), .NUM_REGS(NR)) dut (
    .clock(clock), .isReset(isReset), .instrReq(instrReq), .instrAddr(instrAddr),
    .instrValid(instrValid), .instrData(instrData), .debugRegSel(debugRegSel),
    .pc(pc), .instruction(instruction), .accumulator(accumulator),
    .debugRegData(debugRegData), .aluResult(aluResult), .carry(carry),
    .zero(zero), .halted(halted), .illegal(illegal)
  );

  typedef struct {
    logic [IW-1:0] ins;
    logic [RI-1:0] sel;
    logic [RW-1:0] acc;
    logic [RW-1:0] alu;
    logic [RW-1:0] dbg;
    logic          c;
    logic          z;
    logic          ill;
    logic          hlt;
    logic [PW-1:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [IW-1:0] ins, input logic [RI-1:0] sel,
                              input logic [RW-1:0] acc, input logic [RW-1:0] alu,
                              input logic [RW-1:0] dbg, input logic c, input logic z,
                              input logic ill, input logic hlt, input logic [PW-1:0] pcv);
    vec_t v;
    v.ins = ins; v.sel = sel; v.acc = acc; v.alu = alu; v.dbg = dbg;
    v.c = c; v.z = z; v.ill = ill; v.hlt = hlt; v.pc = pcv;
    return v;
  endfunction

  // Called in FETCH away from the clock edge; returns after the execute edge.
  task automatic exec_one(input logic [IW-1:0] ins, output logic ill_seen);
    check("instrReq_fetch", instrReq, 1);
    instrValid = 1'b1;
    instrData  = ins;
    @(negedge clock);
    instrValid = 1'b0;
    instrData  = '0;
    ill_seen   = illegal;
    check("instrReq_exec", instrReq, 0);
    @(negedge clock);
  endtask

  initial begin
    logic ill;

    // ins, sel, acc, alu, dbg, c, z, ill, hlt, pc
    tbl.push_back(mk(12'h105, 1, 8'h05, 8'h05, 8'h00, 0, 0, 0, 0, 8'h01)); // LDI 05
    tbl.push_back(mk(12'h701, 1, 8'h05, 8'h05, 8'h05, 0, 0, 0, 0, 8'h02)); // STR r1
    tbl.push_back(mk(12'h903, 1, 8'h08, 8'h08, 8'h05, 0, 0, 0, 0, 8'h03)); // ADDI 03
    tbl.push_back(mk(12'h1FF, 2, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h04)); // LDI FF
    tbl.push_back(mk(12'h702, 2, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h05)); // STR r2
    tbl.push_back(mk(12'h101, 2, 8'h01, 8'h01, 8'hFF, 0, 0, 0, 0, 8'h06)); // LDI 01
    tbl.push_back(mk(12'h202, 2, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0, 8'h07)); // ADD r2 -> carry
    tbl.push_back(mk(12'h302, 2, 8'h01, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h08)); // SUB r2 -> borrow
    tbl.push_back(mk(12'h401, 1, 8'h01, 8'h01, 8'h05, 1, 0, 0, 0, 8'h09)); // AND r1
    tbl.push_back(mk(12'h601, 1, 8'h04, 8'h04, 8'h05, 1, 0, 0, 0, 8'h0A)); // XOR r1
    tbl.push_back(mk(12'h502, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h0B)); // OR r2
    tbl.push_back(mk(12'h901, 2, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0, 8'h0C)); // ADDI 01 -> wrap
    tbl.push_back(mk(12'hE00, 2, 8'h00, 8'h00, 8'hFF, 1, 1, 1, 0, 8'h0D)); // illegal E
    tbl.push_back(mk(12'hB10, 2, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0, 8'h10)); // JZ taken
    tbl.push_back(mk(12'h101, 2, 8'h01, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h11)); // LDI 01
    tbl.push_back(mk(12'hB10, 2, 8'h01, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h12)); // JZ not taken
    tbl.push_back(mk(12'h301, 1, 8'hFC, 8'hFC, 8'h05, 1, 0, 0, 0, 8'h13)); // SUB r1 borrow
    tbl.push_back(mk(12'h901, 1, 8'hFD, 8'hFD, 8'h05, 0, 0, 0, 0, 8'h14)); // ADDI 01 no carry
    tbl.push_back(mk(12'hC40, 1, 8'hFD, 8'hFD, 8'h05, 0, 0, 0, 0, 8'h15)); // JC not taken
    tbl.push_back(mk(12'h303, 3, 8'hFD, 8'hFD, 8'h00, 0, 0, 0, 0, 8'h16)); // SUB r3 (=0)
    tbl.push_back(mk(12'h903, 3, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h17)); // ADDI 03 -> carry
    tbl.push_back(mk(12'hC40, 3, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h40)); // JC taken
    tbl.push_back(mk(12'h802, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h41)); // LDR r2, carry kept
    tbl.push_back(mk(12'hF0C, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 0, 8'h42)); // illegal F
    tbl.push_back(mk(12'h000, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h43)); // NOP
    tbl.push_back(mk(12'hAFF, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'hFF)); // JMP FF
    tbl.push_back(mk(12'h000, 2, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h00)); // NOP at FF -> wrap
    tbl.push_back(mk(12'h7FD, 1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h01)); // STR r1 (upper imm ignored)
    tbl.push_back(mk(12'h100, 1, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0, 8'h02)); // LDI 00
    tbl.push_back(mk(12'hD00, 1, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 1, 8'h02)); // HALT

    isReset     = 1'b1;
    instrValid  = 1'b0;
    instrData   = '0;
    debugRegSel = '0;
    repeat (2) @(negedge clock);
    check("rst_instrReq", instrReq, 0);
    check("rst_pc", pc, 0);
    check("rst_instruction", instruction, 0);
    check("rst_acc", accumulator, 0);
    check("rst_alu", aluResult, 0);
    check("rst_flags", {carry, zero, halted, illegal}, 0);
    check("rst_reg0", debugRegData, 0);
    isReset = 1'b0;
    #1;
    check("post_rst_instrReq", instrReq, 1);
    check("post_rst_addr", instrAddr, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      debugRegSel = tbl[i].sel;
      exec_one(tbl[i].ins, ill);
      check($sformatf("illegal_exec[%0d]", i), ill, tbl[i].ill);
      check($sformatf("illegal_after[%0d]", i), illegal, 0);
      check($sformatf("instruction[%0d]", i), instruction, tbl[i].ins);
      check($sformatf("acc[%0d]", i), accumulator, tbl[i].acc);
      check($sformatf("aluResult[%0d]", i), aluResult, tbl[i].alu);
      check($sformatf("debugReg[%0d]", i), debugRegData, tbl[i].dbg);
      check($sformatf("carry[%0d]", i), carry, tbl[i].c);
      check($sformatf("zero[%0d]", i), zero, tbl[i].z);
      check($sformatf("pc[%0d]", i), pc, tbl[i].pc);
      check($sformatf("halted[%0d]", i), halted, tbl[i].hlt);
      check($sformatf("instrReq[%0d]", i), instrReq, !tbl[i].hlt);
      if (!tbl[i].hlt) check($sformatf("instrAddr[%0d]", i), instrAddr, tbl[i].pc);
    end

    // HALTED is terminal: stray instrValid must be ignored
    debugRegSel = 2'd1;
    instrValid  = 1'b1;
    instrData   = 12'h1AA;
    repeat (3) @(negedge clock);
    check("halt_hold_halted", halted, 1);
    check("halt_hold_req", instrReq, 0);
    check("halt_hold_pc", pc, 8'h02);
    check("halt_hold_acc", accumulator, 8'h00);
    check("halt_hold_instr", instruction, 12'hD00);
    check("halt_hold_r1", debugRegData, 8'hFF);

    // Reset exits HALTED and clears the register file
    instrValid = 1'b0;
    isReset    = 1'b1;
    @(negedge clock);
    isReset = 1'b0;
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_req", instrReq, 1);
    check("halt_rst_pc", pc, 0);
    check("halt_rst_r1", debugRegData, 0);

    // Build non-zero state, then reset while a fetch is being offered
    exec_one(12'h15A, ill);
    exec_one(12'h701, ill);
    exec_one(12'h9C0, ill);
    check("pre_rst_acc", accumulator, 8'h1A);
    check("pre_rst_carry", carry, 1);
    check("pre_rst_r1", debugRegData, 8'h5A);
    check("pre_rst_pc", pc, 8'h03);
    instrValid = 1'b1;
    instrData  = 12'h177;
    isReset    = 1'b1;
    @(negedge clock);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_instruction", instruction, 0);
    check("mid_rst_acc", accumulator, 0);
    check("mid_rst_alu", aluResult, 0);
    check("mid_rst_flags", {carry, zero, halted, illegal}, 0);
    check("mid_rst_r1", debugRegData, 0);
    check("mid_rst_req", instrReq, 0);
    instrValid = 1'b0;
    instrData  = '0;
    isReset    = 1'b0;
    #1;
    check("mid_rst_req_after", instrReq, 1);

    // Three wait states, then accept on the fourth fetch cycle
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("wait_req[%0d]", k), instrReq, 1);
      check($sformatf("wait_addr[%0d]", k), instrAddr, 0);
      check($sformatf("wait_pc[%0d]", k), pc, 0);
      check($sformatf("wait_instr[%0d]", k), instruction, 0);
    end
    exec_one(12'h133, ill);
    check("wait_acc", accumulator, 8'h33);
    check("wait_pc_after", pc, 8'h01);
    check("wait_instr_after", instruction, 12'h133);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
